ball_ctrl: RTL and testbench
============================

BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 Parameter SPEED, 2, ball pixels moved per axis per frame tick.
REQ-002 Parameter XINIT, 320 / YINIT, 240, serve position of the ball.
REQ-003 Parameter XLIM, 628 / YLIM, 463, maximum legal ball_x / ball_y.
REQ-004 Parameter WIN_SCORE, 5, goals needed to win.
REQ-005 Parameter SERVE_FRAMES, 60, frame ticks the ball is held before play resumes.
REQ-006 clock  in  1  single system clock, all state on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high; sets all state to reset values.
REQ-008 screenEnd  in  1  level from the VGA timing; its rising edge is the frame tick.
REQ-009 start  in  1  single-cycle pulse that begins a game.
REQ-010 p1_leftBound, p1_rightBound, p2_leftBound, p2_rightBound  in  10 each  paddle x extents, inclusive.
REQ-011 p1_topBound, p1_bottomBound, p2_topBound, p2_bottomBound  in  9 each  paddle y extents, inclusive.
REQ-012 segLeft_topBound, segLeft_bottomBound, segRight_topBound, segRight_bottomBound  in  9 each  goal mouth y extents, inclusive.
REQ-013 ball_x  out  10 / ball_y  out  9  registered ball reference position.
REQ-014 score1, score2  out  4 each  registered goal counts.
REQ-015 winner  out  3  0 none, 1 player 1, 2 player 2; other codes never driven.
REQ-016 state  out  3  current FSM state code; frame_done  out  1  one-cycle pulse after each PLAY update.

Function
REQ-017 Tick is the synchronous rising edge of screenEnd: screenEnd high this cycle and low in the previous registered sample; exactly one clock wide.
REQ-018 FSM states: IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAMEOVER=4.
REQ-019 IDLE: ball held at XINIT/YINIT. start moves to SERVE with scores cleared, winner=0, serve counter=0.
REQ-020 SERVE: each tick increments the serve counter. The tick that makes the count equal SERVE_FRAMES moves to PLAY and clears the counter. The ball does not move.
REQ-021 PLAY: each tick performs one update (REQ-022..REQ-026) and asserts frame_done in the following cycle. start is ignored.
REQ-022 Y update: if dy is down and ball_y+SPEED >= YLIM, then ball_y=YLIM and dy is set to up. If dy is up and ball_y <= SPEED, then ball_y=0 and dy is set to down. Otherwise ball_y moves by SPEED in direction dy.
REQ-023 X priority, first match wins: paddle hit, then edge/goal, then free move.
REQ-024 Paddle hit when the ball is inside a paddle's x and y extents (inclusive) and moving toward it:
- P1, with dx=left: dx set to right, ball_x=p1_rightBound+1.
- P2, with dx=right: dx set to left, ball_x=p2_leftBound-1.
REQ-025 Left edge (dx=left, ball_x <= SPEED):
- ball_y within the segLeft extents: goal for player 2, score2+1, go to SCORED.
- otherwise: ball_x=0, dx set to right.
REQ-026 Right edge (dx=right, ball_x+SPEED >= XLIM):
- ball_y within the segRight extents: goal for player 1, score1+1, go to SCORED.
- otherwise: ball_x=XLIM, dx set to left.
REQ-027 Free move: ball_x moves by SPEED in direction dx.
REQ-028 X and Y updates both apply on the same tick.
REQ-029 All sums are computed at 11 bits (x) and 10 bits (y) before comparison, so no wrap-around occurs.
REQ-030 SCORED lasts exactly one clock, and any tick arriving in that cycle is discarded.
- If the scoring player's count equals WIN_SCORE: go to GAMEOVER with winner set to that player.
- Otherwise: go to SERVE with the ball at XINIT/YINIT, dx pointing toward the player who conceded, and dy unchanged.
REQ-031 GAMEOVER: all outputs hold. start behaves as in REQ-019.
REQ-032 If start and a tick occur in the same cycle in IDLE or GAMEOVER, start takes effect and the tick is not counted.
REQ-033 Scores saturate at 15. They are never incremented outside SCORED entry.

Reset
REQ-034 Reset values:
- state=IDLE; ball_x=XINIT, ball_y=YINIT; dx=right, dy=down.
- score1=score2=0, winner=0, frame_done=0.
- serve counter=0, screenEnd sample=0.
REQ-035 Reset asserted mid-PLAY or mid-SERVE aborts immediately. No goal or score update completes.

Structure
REQ-036 The shared package pong_pkg holds the FSM state codes, the dx/dy direction encodings, the winner codes, and the default geometry constants (XINIT, YINIT, XLIM, YLIM).
REQ-037 The edge detector is the sub-module rise_detect (clock, reset, in, pulse). All other logic lives in ball_ctrl.

Verification
REQ-038 Directed scenarios:
- Reset, then start, then 60 ticks: state=PLAY at tick 60 and ball at (320,240). The next tick gives (322,242) with frame_done high for one cycle.
- Ball at y=462 with dy=down: the next tick gives ball_y=463 and dy=up. At y=1 with dy=up: ball_y=0 and dy=down.
- P1 paddle at x 55..105, y 207..273; ball at (100,240) with dx=left: the tick gives ball_x=106 and dx=right, and score2 is unchanged.
- Ball at (1,240) with dx=left and segLeft 200..280: score2=1, SCORED for one cycle, then SERVE at (320,240) with dx=left. Same setup with ball_y=100: ball_x=0, dx=right, no score.
- Score1=4 and a right goal: score1=5, winner=1, state=GAMEOVER. A later start gives scores 0, winner 0, state SERVE.
- Reset pulsed mid-PLAY: all outputs are at reset values within the same cycle. A start pulse coincident with a tick in IDLE leaves the serve counter at 0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM codes, travel directions, winner codes and
// default playfield geometry.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    SCORED   = 3'd3,
    GAMEOVER = 3'd4
  } ctrlState;

  typedef enum logic { RIGHT = 1'b0, LEFT = 1'b1 } xDir;
  typedef enum logic { DOWN  = 1'b0, UP   = 1'b1 } yDir;

  typedef enum logic [2:0] {
    WIN_NONE = 3'd0,
    WIN_P1   = 3'd1,
    WIN_P2   = 3'd2
  } winCode;

  localparam int XINIT_DEF = 320;
  localparam int YINIT_DEF = 240;
  localparam int XLIM_DEF  = 628;
  localparam int YLIM_DEF  = 463;

  // Inclusive range test; an extent with lo > hi matches nothing.
  function automatic logic inRange(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one-clock pulse when the input goes from low to high.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic inPrev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) inPrev <= 1'b0;
    else       inPrev <= in;
  end

  assign pulse = in & ~inPrev;

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball controller: serve timing, per-frame ball motion with wall,
// paddle and goal handling, scoring and game-over detection.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int SPEED        = 2,
  parameter int XINIT        = XINIT_DEF,
  parameter int YINIT        = YINIT_DEF,
  parameter int XLIM         = XLIM_DEF,
  parameter int YLIM         = YLIM_DEF,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       start,
  input  logic [9:0] p1_leftBound,
  input  logic [9:0] p1_rightBound,
  input  logic [9:0] p2_leftBound,
  input  logic [9:0] p2_rightBound,
  input  logic [8:0] p1_topBound,
  input  logic [8:0] p1_bottomBound,
  input  logic [8:0] p2_topBound,
  input  logic [8:0] p2_bottomBound,
  input  logic [8:0] segLeft_topBound,
  input  logic [8:0] segLeft_bottomBound,
  input  logic [8:0] segRight_topBound,
  input  logic [8:0] segRight_bottomBound,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] winner,
  output logic [2:0] state,
  output logic       frame_done
);

  localparam logic [10:0] SPD_X   = 11'(SPEED);
  localparam logic [9:0]  SPD_Y   = 10'(SPEED);
  localparam logic [10:0] XLIM_X  = 11'(XLIM);
  localparam logic [9:0]  YLIM_Y  = 10'(YLIM);
  localparam logic [9:0]  XINIT_X = 10'(XINIT);
  localparam logic [8:0]  YINIT_Y = 9'(YINIT);
  localparam logic [3:0]  WIN_CNT = 4'(WIN_SCORE);
  localparam int          CW      = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

  function automatic logic [3:0] satInc(input logic [3:0] s);
    return (s == 4'd15) ? s : s + 4'd1;
  endfunction

  ctrlState      stateQ, stateN;
  logic [9:0]    xQ, xN;
  logic [8:0]    yQ, yN;
  xDir           dxQ, dxN;
  yDir           dyQ, dyN;
  logic [3:0]    s1Q, s1N, s2Q, s2N;
  winCode        winQ, winN;
  logic          fdQ, fdN;
  logic [CW-1:0] cntQ, cntN;
  logic          p2ScoredQ, p2ScoredN;
  logic          tick;
  logic [10:0]   xSum;
  logic [9:0]    ySum;
  logic          hitP1, hitP2, inLeftMouth, inRightMouth;

  rise_detect uRise (
    .clock (clock),
    .reset (reset),
    .in    (screenEnd),
    .pulse (tick)
  );

  // Sums are one bit wider than the position so edge tests never wrap.
  assign xSum = 11'(xQ) + SPD_X;
  assign ySum = 10'(yQ) + SPD_Y;

  assign hitP1 = (dxQ == LEFT)
              && inRange(11'(xQ), 11'(p1_leftBound), 11'(p1_rightBound))
              && inRange(11'(yQ), 11'(p1_topBound), 11'(p1_bottomBound));
  assign hitP2 = (dxQ == RIGHT)
              && inRange(11'(xQ), 11'(p2_leftBound), 11'(p2_rightBound))
              && inRange(11'(yQ), 11'(p2_topBound), 11'(p2_bottomBound));
  assign inLeftMouth  = inRange(11'(yQ), 11'(segLeft_topBound), 11'(segLeft_bottomBound));
  assign inRightMouth = inRange(11'(yQ), 11'(segRight_topBound), 11'(segRight_bottomBound));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ    <= IDLE;
      xQ        <= XINIT_X;
      yQ        <= YINIT_Y;
      dxQ       <= RIGHT;
      dyQ       <= DOWN;
      s1Q       <= 4'd0;
      s2Q       <= 4'd0;
      winQ      <= WIN_NONE;
      fdQ       <= 1'b0;
      cntQ      <= '0;
      p2ScoredQ <= 1'b0;
    end else begin
      stateQ    <= stateN;
      xQ        <= xN;
      yQ        <= yN;
      dxQ       <= dxN;
      dyQ       <= dyN;
      s1Q       <= s1N;
      s2Q       <= s2N;
      winQ      <= winN;
      fdQ       <= fdN;
      cntQ      <= cntN;
      p2ScoredQ <= p2ScoredN;
    end
  end

  always_comb begin
    stateN    = stateQ;
    xN        = xQ;
    yN        = yQ;
    dxN       = dxQ;
    dyN       = dyQ;
    s1N       = s1Q;
    s2N       = s2Q;
    winN      = winQ;
    fdN       = 1'b0;
    cntN      = cntQ;
    p2ScoredN = p2ScoredQ;

    case (stateQ)
      IDLE: begin
        xN = XINIT_X;
        yN = YINIT_Y;
      end
      SERVE: if (tick) begin
        if (cntQ == SERVE_LAST) begin
          stateN = PLAY;
          cntN   = '0;
        end else begin
          cntN = cntQ + 1'b1;
        end
      end
      PLAY: if (tick) begin
        fdN = 1'b1;
        if (dyQ == DOWN) begin
          if (ySum >= YLIM_Y) begin
            yN  = YLIM_Y[8:0];
            dyN = UP;
          end else begin
            yN = yQ + SPD_Y[8:0];
          end
        end else if (10'(yQ) <= SPD_Y) begin
          yN  = 9'd0;
          dyN = DOWN;
        end else begin
          yN = yQ - SPD_Y[8:0];
        end

        // Paddle contact outranks the goal line, which outranks free motion.
        if (hitP1) begin
          xN  = p1_rightBound + 10'd1;
          dxN = RIGHT;
        end else if (hitP2) begin
          xN  = p2_leftBound - 10'd1;
          dxN = LEFT;
        end else if ((dxQ == LEFT) && (11'(xQ) <= SPD_X)) begin
          if (inLeftMouth) begin
            s2N       = satInc(s2Q);
            p2ScoredN = 1'b1;
            stateN    = SCORED;
          end else begin
            xN  = 10'd0;
            dxN = RIGHT;
          end
        end else if ((dxQ == RIGHT) && (xSum >= XLIM_X)) begin
          if (inRightMouth) begin
            s1N       = satInc(s1Q);
            p2ScoredN = 1'b0;
            stateN    = SCORED;
          end else begin
            xN  = XLIM_X[9:0];
            dxN = LEFT;
          end
        end else if (dxQ == LEFT) begin
          xN = xQ - SPD_X[9:0];
        end else begin
          xN = xQ + SPD_X[9:0];
        end
      end
      SCORED: begin
        if (p2ScoredQ ? (s2Q == WIN_CNT) : (s1Q == WIN_CNT)) begin
          stateN = GAMEOVER;
          winN   = p2ScoredQ ? WIN_P2 : WIN_P1;
        end else begin
          stateN = SERVE;
          xN     = XINIT_X;
          yN     = YINIT_Y;
          dxN    = p2ScoredQ ? LEFT : RIGHT;
          cntN   = '0;
        end
      end
      GAMEOVER: ;
      default: stateN = IDLE;
    endcase

    // A start in IDLE or GAMEOVER wins over any tick seen in the same cycle.
    if (start && ((stateQ == IDLE) || (stateQ == GAMEOVER))) begin
      stateN = SERVE;
      xN     = XINIT_X;
      yN     = YINIT_Y;
      s1N    = 4'd0;
      s2N    = 4'd0;
      winN   = WIN_NONE;
      cntN   = '0;
    end
  end

  assign ball_x     = xQ;
  assign ball_y     = yQ;
  assign score1     = s1Q;
  assign score2     = s2Q;
  assign winner     = winQ;
  assign state      = stateQ;
  assign frame_done = fdQ;

endmodule

// File: tb/tb_ball_ctrl.sv
// Scoreboard bench for ball_ctrl: directed rallies with hand-derived ball
// positions, checked whenever frame_done is presented.
module tb_ball_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       screenEnd, start;
  logic [9:0] p1_leftBound, p1_rightBound, p2_leftBound, p2_rightBound;
  logic [8:0] p1_topBound, p1_bottomBound, p2_topBound, p2_bottomBound;
  logic [8:0] segLeft_topBound, segLeft_bottomBound, segRight_topBound, segRight_bottomBound;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score1, score2;
  logic [2:0] winner, state;
  logic       frame_done;

  ball_ctrl dut (
    .clock(clock), .reset(reset), .screenEnd(screenEnd), .start(start),
    .p1_leftBound(p1_leftBound), .p1_rightBound(p1_rightBound),
    .p2_leftBound(p2_leftBound), .p2_rightBound(p2_rightBound),
    .p1_topBound(p1_topBound), .p1_bottomBound(p1_bottomBound),
    .p2_topBound(p2_topBound), .p2_bottomBound(p2_bottomBound),
    .segLeft_topBound(segLeft_topBound), .segLeft_bottomBound(segLeft_bottomBound),
    .segRight_topBound(segRight_topBound), .segRight_bottomBound(segRight_bottomBound),
    .ball_x(ball_x), .ball_y(ball_y), .score1(score1), .score2(score2),
    .winner(winner), .state(state), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string nm;
    bit    chkPos;
    int    x, y, s1, s2, st;
  } expT;

  expT sbq[$];
  expT e;
  int  checks = 0;
  int  errors = 0;
  int  kTick  = 0;
  int  curS1  = 0;
  int  curS2  = 0;
  bit  fdPrev = 1'b0;

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: every frame_done pulse consumes one expected update.
  always @(negedge clock) begin
    if (fdPrev) cmp("frame_done_one_cycle", int'(frame_done), 0);
    if (frame_done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_unexpected actual=1 required=0");
      end else begin
        e = sbq.pop_front();
        cmp({e.nm, "_state"}, int'(state), e.st);
        cmp({e.nm, "_score1"}, int'(score1), e.s1);
        cmp({e.nm, "_score2"}, int'(score2), e.s2);
        if (e.chkPos) begin
          cmp({e.nm, "_x"}, int'(ball_x), e.x);
          cmp({e.nm, "_y"}, int'(ball_y), e.y);
        end
      end
    end
    fdPrev = frame_done;
  end

  task automatic tick(input bit withStart);
    @(negedge clock);
    screenEnd = 1'b1;
    start     = withStart;
    @(negedge clock);
    screenEnd = 1'b0;
    start     = 1'b0;
  endtask

  task automatic serveTicks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic push(input string nm, input bit chk, input int x, input int y,
                      input int s1, input int s2, input int st);
    expT t;
    t.nm = nm; t.chkPos = chk; t.x = x; t.y = y; t.s1 = s1; t.s2 = s2; t.st = st;
    sbq.push_back(t);
  endtask

  // Free-running PLAY ticks up to target-1, then one checked tick at target.
  task automatic at(input string nm, input int target, input int x, input int y,
                    input int st);
    while (kTick < target - 1) begin
      push("free", 1'b0, 0, 0, curS1, curS2, 2);
      tick(1'b0);
      kTick++;
    end
    if (st == 3 && x < 300) curS2++;
    else if (st == 3) curS1++;
    push(nm, 1'b1, x, y, curS1, curS2, st);
    tick(1'b0);
    kTick++;
  endtask

  task automatic checkOut(input string nm, input int x, input int y, input int s1,
                          input int s2, input int win, input int st);
    cmp({nm, "_x"}, int'(ball_x), x);
    cmp({nm, "_y"}, int'(ball_y), y);
    cmp({nm, "_score1"}, int'(score1), s1);
    cmp({nm, "_score2"}, int'(score2), s2);
    cmp({nm, "_winner"}, int'(winner), win);
    cmp({nm, "_state"}, int'(state), st);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; screenEnd = 1'b0; start = 1'b0;
    p1_leftBound = 10'd55;   p1_rightBound = 10'd105;
    p1_topBound  = 9'd100;   p1_bottomBound = 9'd200;
    p2_leftBound = 10'd1023; p2_rightBound = 10'd0;
    p2_topBound  = 9'd511;   p2_bottomBound = 9'd0;
    segLeft_topBound  = 9'd511; segLeft_bottomBound  = 9'd0;
    segRight_topBound = 9'd200; segRight_bottomBound = 9'd280;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOut("reset", 320, 240, 0, 0, 0, 0);
    cmp("reset_frame_done", int'(frame_done), 0);

    tick(1'b0);
    cmp("idle_tick_ignored_state", int'(state), 0);
    tick(1'b1);
    cmp("start_with_tick_state", int'(state), 1);
    serveTicks(59);
    cmp("serve_59_state", int'(state), 1);
    tick(1'b0);
    checkOut("serve_60", 320, 240, 0, 0, 0, 2);

    // Game 1: first rally ends in a right goal after a wall bounce and a P1 return.
    kTick = 0;
    at("k1", 1, 322, 242, 2);
    push("start_in_play", 1'b1, 324, 244, 0, 0, 2);
    tick(1'b1);
    kTick++;
    at("y461_down", 111, 542, 462, 2);
    at("y_bottom", 112, 544, 463, 2);
    at("y_up", 113, 546, 461, 2);
    at("x626", 153, 626, 381, 2);
    at("right_bounce", 154, 628, 379, 2);
    at("x_left", 155, 626, 377, 2);
    at("y1_up", 343, 250, 1, 2);
    at("y_top", 344, 248, 0, 2);
    at("y_down", 345, 246, 2, 2);
    at("in_paddle", 416, 104, 144, 2);
    at("p1_hit", 417, 106, 146, 2);
    at("after_hit", 418, 108, 148, 2);
    at("y462_b", 575, 422, 462, 2);
    at("y_bottom_b", 576, 424, 463, 2);
    at("x626_b", 677, 626, 261, 2);
    at("goal_p1", 678, 626, 259, 3);
    @(negedge clock);
    checkOut("serve_after_goal1", 320, 240, 1, 0, 0, 1);

    // Rallies 2..5: whole right mouth open, dy alternates between rallies.
    segRight_topBound = 9'd0; segRight_bottomBound = 9'd511;
    for (int r = 2; r <= 5; r++) begin
      serveTicks(60);
      cmp("rally_play_state", int'(state), 2);
      kTick = 0;
      if (r % 2 == 0) begin
        at("up_k1", 1, 322, 238, 2);
        at("up_y2", 119, 558, 2, 2);
        at("up_top", 120, 560, 0, 2);
        at("up_down", 121, 562, 2, 2);
        at("up_goal", 154, 626, 68, 3);
      end else begin
        at("dn_k1", 1, 322, 242, 2);
        at("dn_y462", 111, 542, 462, 2);
        at("dn_bottom", 112, 544, 463, 2);
        at("dn_goal", 154, 626, 379, 3);
      end
      @(negedge clock);
      if (r < 5) cmp("rally_serve_state", int'(state), 1);
    end
    checkOut("gameover", 626, 379, 5, 0, 1, 4);
    serveTicks(3);
    checkOut("gameover_hold", 626, 379, 5, 0, 1, 4);

    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    checkOut("restart", 320, 240, 0, 0, 0, 1);
    curS1 = 0; curS2 = 0;

    // Game 2: no P1 paddle; left edge bounces first, then a left goal.
    p1_leftBound = 10'd1023; p1_rightBound = 10'd0;
    segRight_topBound = 9'd200; segRight_bottomBound = 9'd280;
    serveTicks(60);
    kTick = 0;
    at("g2_k1", 1, 322, 238, 2);
    at("g2_right_bounce", 154, 628, 68, 2);
    at("g2_left", 155, 626, 70, 2);
    at("g2_y462", 351, 234, 462, 2);
    at("g2_bottom", 352, 232, 463, 2);
    at("g2_x2", 467, 2, 233, 2);
    at("left_bounce", 468, 0, 231, 2);
    segLeft_topBound = 9'd0; segLeft_bottomBound = 9'd511;
    at("g2_right", 469, 2, 229, 2);
    at("g2_y1", 583, 230, 1, 2);
    at("g2_top", 584, 232, 0, 2);
    at("g2_x626", 781, 626, 394, 2);
    at("g2_right_bounce2", 782, 628, 396, 2);
    at("g2_y462b", 815, 562, 462, 2);
    at("g2_bottom2", 816, 560, 463, 2);
    at("g2_y1b", 1047, 98, 1, 2);
    at("g2_top2", 1048, 96, 0, 2);
    at("g2_x2b", 1095, 2, 94, 2);
    at("goal_p2", 1096, 2, 96, 3);
    @(negedge clock);
    checkOut("serve_after_goal2", 320, 240, 0, 1, 0, 1);
    serveTicks(60);
    kTick = 0;
    at("serve_dx_left", 1, 318, 242, 2);
    at("pre_reset", 2, 316, 244, 2);

    // Asynchronous reset while frame_done is high.
    #2 reset = 1'b1;
    #1 checkOut("async_reset", 320, 240, 0, 0, 0, 0);
    cmp("async_reset_frame_done", int'(frame_done), 0);
    @(negedge clock);
    reset = 1'b0;
    tick(1'b1);
    cmp("restart_with_tick_state", int'(state), 1);
    serveTicks(59);
    cmp("restart_serve_59_state", int'(state), 1);
    tick(1'b0);
    cmp("restart_serve_60_state", int'(state), 2);

    repeat (2) @(negedge clock);
    cmp("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
